// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial two's-complement datapath blocks.
package serial_pkg;

    // Frame sequencing states of the serial front end.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Bit-counter width for a serial word of w bits (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: one-entry hold register feeding an LSB-first
// shifter, framed by a one-cycle start pulse so words can stream back to back.
module word_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_start,
    output logic             ser_en,
    output logic             ser_x,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_n;
    logic [WIDTH-1:0]   shifter, shifter_n;
    logic [WIDTH-1:0]   hold_data, hold_data_n;
    logic               hold_full, hold_full_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               accept;

    // Hold refills only when empty, so a pull and an accept never coincide.
    assign accept = in_valid & ~hold_full;

    // Next-state: capture into hold, pull hold into shifter at frame boundaries.
    always_comb begin
        state_n     = state;
        shifter_n   = shifter;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        cnt_n       = cnt;

        if (accept) begin
            hold_data_n = in_data;
            hold_full_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    shifter_n   = hold_data;
                    hold_full_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = START;
                end
            end
            START: begin
                state_n = SHIFT;
            end
            SHIFT: begin
                shifter_n = {1'b0, shifter[WIDTH-1:1]};
                cnt_n     = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (hold_full) begin
                        shifter_n   = hold_data;
                        hold_full_n = 1'b0;
                        state_n     = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shifter   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            shifter   <= shifter_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
        end
    end

    // Outputs are flopped decodes of the next state, so they equal decodes of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            ser_start <= 1'b0;
            ser_en    <= 1'b0;
            ser_x     <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= ~hold_full_n;
            ser_start <= (state_n == START);
            ser_en    <= (state_n != IDLE);
            ser_x     <= (state_n == SHIFT) & shifter_n[0];
            word_done <= (state_n == SHIFT) && (cnt_n == LAST);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: 4-bit and 6-bit instances on one clock.
module tb_word_serializer;

    logic clk = 1'b0;
    logic reset;

    logic       in_valid, in_ready;
    logic [3:0] in_data;
    logic       ser_start, ser_en, ser_x, word_done, busy;

    logic       in_valid6, in_ready6;
    logic [5:0] in_data6;
    logic       ser_start6, ser_en6, ser_x6, word_done6, busy6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_start (ser_start),
        .ser_en    (ser_en),
        .ser_x     (ser_x),
        .word_done (word_done),
        .busy      (busy)
    );

    word_serializer #(.WIDTH(6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .in_data   (in_data6),
        .ser_start (ser_start6),
        .ser_en    (ser_en6),
        .ser_x     (ser_x6),
        .word_done (word_done6),
        .busy      (busy6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all 4-bit outputs at once, packed {start,en,x,done,busy,ready}.
    task automatic chk4(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, ser_start, ser_en, ser_x, word_done, busy, in_ready}, {26'd0, exp});
    endtask

    // One frame of the 4-bit DUT: START cycle then four bits LSB first.
    // Upstream is switched to (nv, nd) right after the edge ending START.
    task automatic frame4(input string tag, input logic [3:0] w, input logic nv, input logic [3:0] nd);
        logic took;
        tick();
        chk4($sformatf("%s_start", tag), 6'b110_011);
        took = in_valid;
        tick();
        in_valid = nv;
        in_data  = nd;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk4($sformatf("%s_bit%0d", tag, i),
                 {1'b0, 1'b1, w[i], (i == 3), 1'b1, ~took});
        end
    endtask

    initial begin
        logic [5:0] w6;
        logic [5:0] z6;
        logic       seen1;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid6 = 1'b0;
        in_data6  = '0;
        #3;
        chk4("reset_state", 6'b000_001);
        chk("reset_state6", {26'd0, ser_start6, ser_en6, ser_x6, word_done6, busy6, in_ready6}, 32'h1);
        tick();
        reset = 1'b0;
        tick();

        // Single word 4'b1100, then idle.
        in_valid = 1'b1;
        in_data  = 4'b1100;
        tick();
        in_valid = 1'b0;
        chk4("single_accept", 6'b000_000);
        frame4("single", 4'b1100, 1'b0, 4'h0);
        tick();
        chk4("single_idle", 6'b000_001);

        // Continuous stream 3, A, F with no idle cycles between frames.
        in_valid = 1'b1;
        in_data  = 4'h3;
        tick();
        in_data  = 4'hA;
        frame4("stream3", 4'h3, 1'b1, 4'hF);
        frame4("streamA", 4'hA, 1'b0, 4'h0);
        frame4("streamF", 4'hF, 1'b0, 4'h0);
        tick();
        chk4("stream_idle", 6'b000_001);

        // Backpressure: second word held off until the START of the first frame.
        in_valid = 1'b1;
        in_data  = 4'h5;
        tick();
        in_data  = 4'h9;
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        frame4("bp5", 4'h5, 1'b0, 4'h0);
        frame4("bp9", 4'h9, 1'b0, 4'h0);
        tick();
        chk4("bp_idle", 6'b000_001);

        // Reset asserted while bit 2 is on the wire and the hold register is full.
        in_valid = 1'b1;
        in_data  = 4'h6;
        tick();
        in_data  = 4'hB;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk4("pre_reset_bit2", 6'b011_010);
        #2;
        reset = 1'b1;
        #1;
        chk4("mid_reset", 6'b000_001);
        #1;
        reset = 1'b0;
        tick();
        chk4("post_reset_idle", 6'b000_001);
        in_valid = 1'b1;
        in_data  = 4'h7;
        tick();
        in_valid = 1'b0;
        frame4("post_reset", 4'h7, 1'b0, 4'h0);

        // Idle gap of ten cycles, then a second word with normal latency.
        in_valid = 1'b1;
        in_data  = 4'h2;
        tick();
        in_valid = 1'b0;
        frame4("gap_first", 4'h2, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("gap_quiet%0d", i), {30'd0, ser_en, ser_start}, 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 4'hD;
        tick();
        in_valid = 1'b0;
        chk4("gap_latency", 6'b000_000);
        frame4("gap_second", 4'hD, 1'b0, 4'h0);

        // 6-bit word 6'b011010 with a serial negator model downstream (expect -26).
        w6 = 6'b011010;
        in_valid6 = 1'b1;
        in_data6  = w6;
        tick();
        in_valid6 = 1'b0;
        tick();
        chk("w6_start", {29'd0, ser_start6, ser_en6, ser_x6}, 32'b110);
        seen1 = 1'b0;
        z6    = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("w6_bit%0d", i), {30'd0, ser_x6, word_done6}, {30'd0, w6[i], (i == 5)});
            z6[i] = seen1 ? ~ser_x6 : ser_x6;
            seen1 = seen1 | ser_x6;
        end
        chk("w6_negated", {26'd0, z6}, {26'd0, 6'b100110});
        tick();
        chk("w6_idle", {30'd0, ser_en6, busy6}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the bit-serial two's-complement datapath. It accepts a WIDTH-bit word over a valid/ready handshake and drives the downstream serial stage (the negator/adder) with a one-cycle frame-start pulse, then the word LSB-first, one bit per clock. A one-entry hold register lets the next word be accepted while the current word is shifting, so back-to-back words stream with no idle cycles.

## Interface
- WIDTH, 4, serial word length in bits (≥ 2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream word available
- in_ready  out  1  hold register empty; word accepted on edge where in_valid & in_ready
- in_data  in  WIDTH  two's-complement word
- ser_start  out  1  frame start; wired to downstream stage's frame reset input
- ser_en  out  1  serial enable to downstream stage
- ser_x  out  1  serial data bit, LSB first
- word_done  out  1  high during the cycle the MSB is on ser_x
- busy  out  1  FSM not in IDLE

## Operation
- Storage: hold register (hold_data, hold_full), shift register (WIDTH bits), bit counter (clog2(WIDTH) bits), FSM.
- in_ready = ~hold_full (registered state, no combinational path from in_valid).
- Accept: in_valid & in_ready at edge → hold_data ← in_data, hold_full ← 1.
- FSM states:
  - IDLE: ser_start=0, ser_en=0, ser_x=0. If hold_full → load shifter from hold, clear hold_full, cnt←0, go START.
  - START: ser_start=1, ser_en=1, ser_x=0 (one cycle). → SHIFT.
  - SHIFT: ser_start=0, ser_en=1, ser_x=shifter[0]; shift right each edge, cnt++. When cnt==WIDTH-1: word_done=1; at that edge, if hold_full → load shifter, clear hold_full, cnt←0, go START; else go IDLE.
- Outputs are registered-state decodes only; no combinational input→output path.
- Words are passed bit-exact; no sign extension or arithmetic.
- Simultaneous pull and accept cannot occur (in_ready is low while hold_full); hold refills from the cycle after the pull.
- in_valid while in_ready=0: ignored; upstream must hold in_data/in_valid stable until accepted.

## Timing
- Reset (async assert): state=IDLE, hold_full=0, cnt=0, shifter=0; ser_start=0, ser_en=0, ser_x=0, word_done=0, busy=0, in_ready=1.
- Reset mid-word: current and held words are discarded; downstream sees ser_en drop immediately; no partial word_done.
- Latency: accept at edge k → ser_start high in cycle after edge k+1 → LSB on ser_x after edge k+2 → MSB after edge k+WIDTH+1.
- Frame length: WIDTH+1 cycles (1 START + WIDTH SHIFT). Sustained throughput: one word per WIDTH+1 cycles when in_valid stays high.
- in_ready falls the cycle after accept, rises the cycle after the FSM pulls the hold register.

## Structure
- Package serial_pkg: FSM state enum (IDLE, START, SHIFT), shared across serial-datapath blocks; counter width derived via $clog2(WIDTH) localparam.
- Single module; no sub-module warranted.

## Test plan
- WIDTH=4, single word 4'b1100 → one START cycle (ser_x=0), then ser_x 0,0,1,1; word_done on 4th bit; with negator downstream z = 0,0,1,0 (+4).
- WIDTH=6, word 6'b011010 → ser_x 0,1,0,1,1,0 after START; negator z = 0,1,1,0,0,1 (6'b100110 = −26).
- WIDTH=4, in_valid held high with 4'h3, 4'hA, 4'hF → frames contiguous: START,4 bits,START,4 bits,START,4 bits; no IDLE cycle between; in_ready low except one cycle per frame.
- Backpressure: accept word, present second word while hold full → in_ready=0, second word not taken until the START of frame 1; data unchanged on ser_x.
- Assert reset during bit 2 of a shifting word with hold full → all outputs 0 immediately, in_ready=1, busy=0; next accepted word starts cleanly with START.
- Idle gap: accept one word, wait 10 cycles, accept another → ser_en=0, ser_start=0 throughout the gap; second frame has correct 2-cycle latency.
